hazard_scoreboard: RTL and testbench

Parametrised register scoreboard that replaces pairwise stage-comparison hazard logic in the in-order RISC-V pipeline. It tracks every in-flight register write, including fixed multi-cycle producers (MUL, loads) and variable-latency producers (cache-miss loads, DIV). From that state it computes, for the instruction in decode, the decode stall, the issue strobe and a per-source forwarding-path select. It sits beside the decode stage and is driven by the decoded instruction and the writeback/completion bus.

---
 rtl/hazard_scoreboard_pkg.sv | 31 +++
 rtl/hazard_scoreboard_sb_entry.sv | 69 ++++++
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the register hazard scoreboard.
// Every scoreboard entry is tracked with one of these records.
package hazard_scoreboard_pkg;

    localparam int SB_NUM_REGS = 32;
    localparam int SB_NUM_FWD  = 2;
    localparam int SB_LAT_W    = 4;
    localparam int SB_AGE_W    = (SB_NUM_FWD > 1) ? $clog2(SB_NUM_FWD) : 1;

    // bypass_sel value that selects the register file.
    localparam int BYPASS_RF = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_FIX = 2'd1,
        WAIT_VAR = 2'd2,
        FWD      = 2'd3
    } sb_state_e;

    typedef struct packed {
        sb_state_e             state;
        logic [SB_LAT_W-1:0]   cnt;
        logic [SB_AGE_W-1:0]   age;
    } sb_entry_t;

    // A register is unreadable while its producer has not yet made a result.
    function automatic logic is_waiting(input sb_state_e st);
        return (st == WAIT_FIX) || (st == WAIT_VAR);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry: tracks the in-flight write to a single register.
// Priority: rst, then a new issue to this register, then writeback, then aging.
module hazard_scoreboard_sb_entry
    import hazard_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_wr,
    input  logic [SB_LAT_W-1:0] lat,
    input  logic                wb_hit,
    output sb_entry_t           entry
);

    sb_entry_t entry_next;

    // Next-state: new producer overrides; otherwise count down, complete or age.
    always_comb begin
        entry_next = entry;
        if (issue_wr) begin
            entry_next.cnt = '0;
            entry_next.age = '0;
            if (lat == '0) begin
                entry_next.state = WAIT_VAR;
            end else if (lat == SB_LAT_W'(1)) begin
                entry_next.state = FWD;
            end else begin
                entry_next.state = WAIT_FIX;
                entry_next.cnt   = lat - SB_LAT_W'(1);
            end
        end else begin
            case (entry.state)
                WAIT_FIX: begin
                    if (entry.cnt > SB_LAT_W'(1)) begin
                        entry_next.cnt = entry.cnt - SB_LAT_W'(1);
                    end else begin
                        entry_next.state = FWD;
                        entry_next.cnt   = '0;
                        entry_next.age   = '0;
                    end
                end
                WAIT_VAR: begin
                    if (wb_hit) begin
                        entry_next.state = FWD;
                        entry_next.age   = '0;
                    end
                end
                FWD: begin
                    if (entry.age < SB_AGE_W'(SB_NUM_FWD - 1)) begin
                        entry_next.age = entry.age + SB_AGE_W'(1);
                    end else begin
                        entry_next.state = IDLE;
                        entry_next.age   = '0;
                    end
                end
                default: entry_next = entry;
            endcase
        end
    end

    // State register with synchronous reset to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry <= '{state: IDLE, cnt: '0, age: '0};
        end else begin
            entry <= entry_next;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard for the in-order pipeline decode stage.
// Handshake: decode presents dec_valid; the instruction leaves decode (issue)
// in any cycle where it is valid, not stalled and not flushed. There is no
// other acceptance signal; stall is the back-pressure to decode/fetch.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS    = SB_NUM_REGS,
    parameter int NUM_SRC     = 2,
    parameter int NUM_FWD     = SB_NUM_FWD,
    parameter int LAT_W       = SB_LAT_W,
    parameter int STALL_CNT_W = 32,
    localparam int REG_W      = $clog2(NUM_REGS),
    localparam int SEL_W      = $clog2(NUM_FWD + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dec_valid,
    input  logic [NUM_SRC*REG_W-1:0]   dec_src_reg,
    input  logic [NUM_SRC-1:0]         dec_src_used,
    input  logic                       dec_we,
    input  logic [REG_W-1:0]           dec_dst_reg,
    input  logic [LAT_W-1:0]           dec_lat,
    input  logic                       flush,
    input  logic                       wb_valid,
    input  logic [REG_W-1:0]           wb_dst_reg,
    output logic                       stall,
    output logic                       issue,
    output logic [NUM_SRC*SEL_W-1:0]   bypass_sel,
    output logic [NUM_REGS-1:0]        busy_vec,
    output logic [STALL_CNT_W-1:0]     stall_cnt,
    output logic                       sb_error
);

    sb_entry_t entries [NUM_REGS];
    logic      raw_hit;
    logic      waw_hit;
    logic      err_set;

    // x0 never has a pending write.
    assign entries[0] = '{state: IDLE, cnt: '0, age: '0};

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        hazard_scoreboard_sb_entry u_entry (
            .clk      (clk),
            .rst      (rst),
            .issue_wr (issue && dec_we && (dec_dst_reg == REG_W'(i))),
            .lat      (dec_lat),
            .wb_hit   (wb_valid && (wb_dst_reg == REG_W'(i))),
            .entry    (entries[i])
        );
    end

    // Source readiness and forwarding-path select for each operand.
    always_comb begin
        raw_hit    = 1'b0;
        bypass_sel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            bypass_sel[s*SEL_W +: SEL_W] = SEL_W'(BYPASS_RF);
            if (dec_src_used[s] && (dec_src_reg[s*REG_W +: REG_W] != '0) &&
                is_waiting(entries[dec_src_reg[s*REG_W +: REG_W]].state)) begin
                raw_hit = 1'b1;
            end
            if (entries[dec_src_reg[s*REG_W +: REG_W]].state == FWD) begin
                bypass_sel[s*SEL_W +: SEL_W] =
                    SEL_W'(entries[dec_src_reg[s*REG_W +: REG_W]].age) + SEL_W'(1);
            end
        end
    end

    // Stall and issue decisions; a flushed instruction neither stalls nor issues.
    always_comb begin
        waw_hit = dec_we && (dec_dst_reg != '0) && is_waiting(entries[dec_dst_reg].state);
        stall   = dec_valid && (raw_hit || waw_hit) && !flush;
        issue   = dec_valid && !stall && !flush;
    end

    // Protocol violations: stray/duplicate completions, or a completion racing an issue.
    always_comb begin
        err_set = 1'b0;
        if (wb_valid) begin
            if ((wb_dst_reg == '0) || (entries[wb_dst_reg].state != WAIT_VAR)) begin
                err_set = 1'b1;
            end
            if (issue && dec_we && (dec_dst_reg == wb_dst_reg)) begin
                err_set = 1'b1;
            end
        end
    end

    // Debug view of which registers have a write in flight.
    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_vec[i] = (entries[i].state != IDLE);
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_error <= 1'b0;
        end else if (err_set) begin
            sb_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline sequences plus random traffic,
// checked against a timestamp model of register availability.
module tb_hazard_scoreboard;

    localparam int NFWD = 2;

    typedef struct {
        logic        stall;
        logic        issue;
        logic [31:0] busy;
        logic        err;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } stat_t;

    logic        clk;
    logic        rst;
    logic        dec_valid;
    logic [9:0]  dec_src_reg;
    logic [1:0]  dec_src_used;
    logic        dec_we;
    logic [4:0]  dec_dst_reg;
    logic [3:0]  dec_lat;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_dst_reg;

    logic        stall, issue, sb_error;
    logic [3:0]  bypass_sel;
    logic [31:0] busy_vec;
    logic [31:0] stall_cnt;

    logic        stall_s, issue_s, err_s;
    logic [3:0]  sel_s;
    logic [31:0] busy_s;
    logic [3:0]  stall_cnt_s;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src_reg(dec_src_reg),
        .dec_src_used(dec_src_used), .dec_we(dec_we), .dec_dst_reg(dec_dst_reg),
        .dec_lat(dec_lat), .flush(flush), .wb_valid(wb_valid), .wb_dst_reg(wb_dst_reg),
        .stall(stall), .issue(issue), .bypass_sel(bypass_sel), .busy_vec(busy_vec),
        .stall_cnt(stall_cnt), .sb_error(sb_error)
    );

    hazard_scoreboard #(.STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src_reg(dec_src_reg),
        .dec_src_used(dec_src_used), .dec_we(dec_we), .dec_dst_reg(dec_dst_reg),
        .dec_lat(dec_lat), .flush(flush), .wb_valid(wb_valid), .wb_dst_reg(wb_dst_reg),
        .stall(stall_s), .issue(issue_s), .bypass_sel(sel_s), .busy_vec(busy_s),
        .stall_cnt(stall_cnt_s), .sb_error(err_s)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  exp_q[$];
    stat_t       stat_q[$];

    // ---------------- reference model ----------------
    // ready_at[r]: first cycle the newest value of r is on forwarding path 0.
    // pend_var[r]: a variable-latency producer has not completed yet.
    int          ready_at[32];
    bit          pend_var[32];
    int          cyc;
    logic        m_err;
    logic [31:0] m_cnt;
    int          m_cnt4;
    bit          last_issue;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            ready_at[r] = -1000;
            pend_var[r] = 1'b0;
        end
        m_err  = 1'b0;
        m_cnt  = '0;
        m_cnt4 = 0;
    endtask

    function automatic bit pending(input int r);
        return (r != 0) && (pend_var[r] || (cyc < ready_at[r]));
    endfunction

    function automatic int fwd_sel(input int r);
        int d;
        if (r == 0 || pend_var[r]) return 0;
        d = cyc - ready_at[r];
        if (d >= 0 && d < NFWD) return d + 1;
        return 0;
    endfunction

    function automatic logic [31:0] busy_model();
        logic [31:0] b;
        b = '0;
        for (int r = 1; r < 32; r++) begin
            b[r] = pend_var[r] || (cyc < ready_at[r] + NFWD);
        end
        return b;
    endfunction

    // One clock cycle with the currently driven inputs: predict, queue, update, advance.
    task automatic cycle();
        stat_t      st;
        logic       raw, waw, wb_ok, same;
        logic [3:0] sel;
        int         r, wr;
        raw = 1'b0;
        sel = '0;
        for (int s = 0; s < 2; s++) begin
            r = int'(dec_src_reg[s*5 +: 5]);
            if (dec_src_used[s] && pending(r)) raw = 1'b1;
            sel[s*2 +: 2] = 2'(fwd_sel(r));
        end
        waw = dec_we && pending(int'(dec_dst_reg));
        st.stall = dec_valid && (raw || waw) && !flush;
        st.issue = dec_valid && !st.stall && !flush;
        st.busy  = busy_model();
        st.err   = m_err;
        st.cnt   = m_cnt;
        st.cnt4  = 4'(m_cnt4);
        stat_q.push_back(st);
        if (st.issue) exp_q.push_back(sel);
        last_issue = st.issue;

        if (rst) begin
            model_clear();
        end else begin
            if (st.stall) begin
                if (m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 1;
                if (m_cnt4 != 15) m_cnt4++;
            end
            wr    = int'(wb_dst_reg);
            same  = st.issue && dec_we && (dec_dst_reg == wb_dst_reg);
            wb_ok = wb_valid && (wr != 0) && pend_var[wr] && !same;
            if (wb_valid && !wb_ok) m_err = 1'b1;
            if (wb_ok) begin
                pend_var[wr] = 1'b0;
                ready_at[wr] = cyc + 1;
            end
            if (st.issue && dec_we && dec_dst_reg != 5'd0) begin
                if (dec_lat == 4'd0) begin
                    pend_var[dec_dst_reg] = 1'b1;
                end else begin
                    pend_var[dec_dst_reg] = 1'b0;
                    ready_at[dec_dst_reg] = cyc + int'(dec_lat);
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_instr(input int s0, input int s1, input logic [1:0] used,
                             input logic we, input int dst, input int lat);
        dec_valid    = 1'b1;
        dec_src_reg  = {5'(s1), 5'(s0)};
        dec_src_used = used;
        dec_we       = we;
        dec_dst_reg  = 5'(dst);
        dec_lat      = 4'(lat);
        flush        = 1'b0;
    endtask

    task automatic idle(input int n);
        dec_valid    = 1'b0;
        dec_we       = 1'b0;
        dec_src_used = '0;
        repeat (n) cycle();
    endtask

    // Hold the current instruction in decode until it issues (bounded).
    task automatic send();
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_issue && n < 64);
        if (!last_issue) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: no issue after %0d cycles, required an issue", n);
        end
    endtask

    task automatic random_phase(input int ncyc);
        int  cand[$];
        bit  need_new;
        need_new = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            if (need_new) begin
                dec_valid    = ($urandom_range(0, 5) != 0);
                dec_src_reg  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
                dec_src_used = 2'($urandom_range(0, 3));
                dec_we       = ($urandom_range(0, 3) != 0);
                dec_dst_reg  = 5'($urandom_range(0, 7));
                dec_lat      = 4'($urandom_range(0, 5));
            end
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            cand  = {};
            for (int r = 1; r < 32; r++) if (pend_var[r]) cand.push_back(r);
            wb_valid = 1'b0;
            if (cand.size() > 0 && $urandom_range(0, 3) == 0) begin
                wb_valid   = 1'b1;
                wb_dst_reg = 5'(cand[$urandom_range(0, cand.size() - 1)]);
            end else if ($urandom_range(0, 59) == 0) begin
                wb_valid   = 1'b1;
                wb_dst_reg = 5'($urandom_range(0, 7));
            end
            need_new = !dec_valid || flush || rst;
            cycle();
            need_new = need_new || last_issue;
        end
        rst      = 1'b0;
        flush    = 1'b0;
        wb_valid = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        stat_t st;
        forever begin
            @(negedge clk);
            if (stat_q.size() > 0) begin
                st = stat_q.pop_front();
                check("stall", stall, st.stall);
                check("issue", issue, st.issue);
                check("busy_vec", busy_vec, st.busy);
                check("sb_error", sb_error, st.err);
                check("stall_cnt", stall_cnt, st.cnt);
                check("stall_cnt_w4", stall_cnt_s, st.cnt4);
            end
            if (issue) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL bypass_sel: unexpected issue with sel %0h, required no issue", bypass_sel);
                end else begin
                    check("bypass_sel", bypass_sel, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] c0;
        rst = 1'b1; dec_valid = 1'b0; dec_src_reg = '0; dec_src_used = '0;
        dec_we = 1'b0; dec_dst_reg = '0; dec_lat = '0; flush = 1'b0;
        wb_valid = 1'b0; wb_dst_reg = '0;
        cyc = 0;
        last_issue = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        check("reset_busy", busy_vec, 32'd0);
        check("reset_err", sb_error, 1'b0);
        check("reset_cnt", stall_cnt, 32'd0);
        idle(1);

        // Single-cycle producer: forward on path 0, then path 1, then register file.
        set_instr(1, 2, 2'b11, 1'b1, 5, 1); send();
        c0 = stall_cnt;
        set_instr(5, 5, 2'b11, 1'b1, 6, 1); send();
        check("add_stalls", stall_cnt - c0, 32'd0);
        set_instr(5, 0, 2'b01, 1'b0, 0, 1); send();
        set_instr(0, 5, 2'b10, 1'b0, 0, 1); send();
        idle(2);

        // Load then dependent store: one bubble.
        set_instr(1, 0, 2'b01, 1'b1, 7, 2); send();
        c0 = stall_cnt;
        set_instr(2, 7, 2'b11, 1'b0, 0, 1); send();
        check("lw_stalls", stall_cnt - c0, 32'd1);
        idle(2);

        // Four-cycle multiply: three bubbles; x0 and unused sources never stall.
        set_instr(1, 2, 2'b11, 1'b1, 8, 4); send();
        c0 = stall_cnt;
        set_instr(8, 0, 2'b01, 1'b1, 3, 1); send();
        check("mul_stalls", stall_cnt - c0, 32'd3);
        set_instr(1, 2, 2'b11, 1'b1, 10, 4); send();
        c0 = stall_cnt;
        set_instr(0, 10, 2'b01, 1'b1, 0, 1); send();
        check("x0_unused_stalls", stall_cnt - c0, 32'd0);
        idle(5);

        // Variable-latency load completing five cycles after issue.
        set_instr(1, 0, 2'b01, 1'b1, 9, 0); send();
        c0 = stall_cnt;
        set_instr(9, 1, 2'b11, 1'b1, 4, 1);
        repeat (4) cycle();
        wb_valid = 1'b1; wb_dst_reg = 5'd9; cycle(); wb_valid = 1'b0;
        send();
        check("var_stalls", stall_cnt - c0, 32'd5);
        idle(3);

        // WAW against a pending variable-latency write.
        set_instr(1, 0, 2'b01, 1'b1, 11, 0); send();
        c0 = stall_cnt;
        set_instr(0, 0, 2'b00, 1'b1, 11, 1);
        repeat (3) cycle();
        wb_valid = 1'b1; wb_dst_reg = 5'd11; cycle(); wb_valid = 1'b0;
        send();
        check("waw_stalls", stall_cnt - c0, 32'd4);
        idle(3);

        // Reset discards a pending load; its late completion is a protocol error.
        set_instr(1, 0, 2'b01, 1'b1, 9, 0); send();
        idle(2);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("rst_busy", busy_vec, 32'd0);
        wb_valid = 1'b1; wb_dst_reg = 5'd9; idle(1); wb_valid = 1'b0;
        check("late_wb_err", sb_error, 1'b1);
        c0 = stall_cnt;
        set_instr(9, 0, 2'b01, 1'b0, 0, 1); send();
        check("after_rst_stalls", stall_cnt - c0, 32'd0);
        idle(1);

        // Flush with a pending RAW: no stall, no issue.
        set_instr(1, 0, 2'b01, 1'b1, 12, 0); send();
        set_instr(12, 0, 2'b01, 1'b1, 13, 1);
        flush = 1'b1; cycle(); flush = 1'b0;
        wb_valid = 1'b1; wb_dst_reg = 5'd12; idle(1); wb_valid = 1'b0;
        idle(3);

        // Counter saturation: 21 stall cycles in a row.
        rst = 1'b1; idle(1); rst = 1'b0;
        set_instr(1, 0, 2'b01, 1'b1, 13, 0); send();
        set_instr(13, 0, 2'b01, 1'b0, 0, 1);
        repeat (20) cycle();
        wb_valid = 1'b1; wb_dst_reg = 5'd13; cycle(); wb_valid = 1'b0;
        send();
        check("sat_cnt_w4", stall_cnt_s, 4'd15);
        check("sat_cnt_w32", stall_cnt, 32'd21);
        idle(3);

        // Random traffic.
        random_phase(800);
        idle(3);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("stat_q_drained", 64'(stat_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
